// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types and constants for the gshare branch predictor.
// Width macros ADDR_WIDTH / INSTRUCTION_WIDTH default to 32 when not supplied by the build.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

package branch_predictor_gshare_pkg;

  localparam int GHR_WIDTH_DEFAULT = 8;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    strong_nt = 2'b00,
    weak_nt   = 2'b01,
    weak_t    = 2'b10,
    strong_t  = 2'b11
  } bp_counter_t;

  // Rename snapshot carried with each branch down to the BRU.
  typedef struct packed {
    logic [GHR_WIDTH_DEFAULT-1:0] global_history;
  } checkpoint_t;

  function automatic bp_counter_t counter_next(input bp_counter_t cnt, input logic taken);
    bp_counter_t result;
    result = cnt;
    if (taken) begin
      if (cnt != strong_t) result = bp_counter_t'(cnt + 2'd1);
    end else begin
      if (cnt != strong_nt) result = bp_counter_t'(cnt - 2'd1);
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_pht.sv
// Pattern history table: one combinational read port for fetch and one clocked
// write port shared by the init sweep (priority) and read-modify-write training.
module bp_pht
  import branch_predictor_gshare_pkg::*;
#(
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output bp_counter_t            rd_data,
  input  logic                   init_we,
  input  logic [INDEX_WIDTH-1:0] init_idx,
  input  logic                   upd_we,
  input  logic [INDEX_WIDTH-1:0] upd_idx,
  input  logic                   upd_taken
);

  bp_counter_t pht_mem [2**INDEX_WIDTH];

  // Fetch sees the pre-write value when it collides with a training write.
  assign rd_data = pht_mem[rd_idx];

  // Training reads the committed entry in the same cycle it writes, so
  // consecutive updates to one index chain correctly without forwarding.
  always_ff @(posedge clk) begin
    if (init_we) begin
      pht_mem[init_idx] <= weak_nt;
    end else if (upd_we) begin
      pht_mem[upd_idx] <= counter_next(pht_mem[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare predictor: PHT init FSM, speculative GHR with mispredict repair, fetch decode
// and two-stage training pipeline. Define BP_STATISTICS_EN to add update/miss counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int GHR_WIDTH       = GHR_WIDTH_DEFAULT,
  parameter int PHT_INDEX_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef BP_STATISTICS_EN
  output logic [31:0]                   bp_stat_total,
  output logic [31:0]                   bp_stat_miss,
`endif
  input  logic                          fetch_bp_valid,
  input  logic [`ADDR_WIDTH-1:0]        fetch_bp_pc,
  input  logic [`INSTRUCTION_WIDTH-1:0] fetch_bp_instruction,
  output logic                          bp_fetch_predicted,
  output logic                          bp_fetch_jump,
  output logic [`ADDR_WIDTH-1:0]        bp_fetch_next_pc,
  output logic [GHR_WIDTH-1:0]          bp_fetch_global_history,
  input  checkpoint_t                   exbru_bp_cp,
  input  logic [`ADDR_WIDTH-1:0]        exbru_bp_pc,
  input  logic [`INSTRUCTION_WIDTH-1:0] exbru_bp_instruction,
  input  logic                          exbru_bp_jump,
  input  logic [`ADDR_WIDTH-1:0]        exbru_bp_next_pc,
  input  logic                          exbru_bp_hit,
  input  logic                          exbru_bp_valid,
  output logic                          bp_ready
);

  localparam int AW  = `ADDR_WIDTH;
  localparam int PIW = PHT_INDEX_WIDTH;

  localparam logic [0:0] STATE_INIT  = 1'b0;
  localparam logic [0:0] STATE_READY = 1'b1;

  logic [0:0]           state_reg;
  logic [PIW-1:0]       init_cnt_reg;
  logic [GHR_WIDTH-1:0] ghr_reg;
  logic                 ready;

  logic                 u_valid_reg;
  logic [PIW-1:0]       u_pc_idx_reg;
  logic                 u_jump_reg;
  logic [GHR_WIDTH-1:0] u_ghr_reg;

  logic [PIW-1:0]       fetch_hist;
  logic [PIW-1:0]       upd_hist;
  logic [PIW-1:0]       fetch_idx;
  logic [PIW-1:0]       upd_idx;
  bp_counter_t          pht_rd_data;

  logic [6:0]           fetch_opcode;
  logic                 fetch_is_branch;
  logic                 fetch_is_jal;
  logic [AW-1:0]        b_imm;
  logic [AW-1:0]        j_imm;
  logic [AW-1:0]        pc_plus4;

  logic                 exbru_is_branch;
  logic                 upd_accept;
  logic                 repair;

  assign ready = (state_reg == STATE_READY);
  assign bp_ready = ready;
  assign bp_fetch_global_history = ghr_reg;

  // History folds into the index zero-extended, or truncated if it is longer.
  generate
    if (GHR_WIDTH >= PIW) begin : g_hist_trunc
      assign fetch_hist = ghr_reg[PIW-1:0];
      assign upd_hist   = u_ghr_reg[PIW-1:0];
    end else begin : g_hist_zext
      assign fetch_hist = {{(PIW-GHR_WIDTH){1'b0}}, ghr_reg};
      assign upd_hist   = {{(PIW-GHR_WIDTH){1'b0}}, u_ghr_reg};
    end
  endgenerate

  assign fetch_idx = fetch_bp_pc[PIW+1:2] ^ fetch_hist;
  assign upd_idx   = u_pc_idx_reg ^ upd_hist;

  bp_pht #(
    .INDEX_WIDTH(PIW)
  ) u_pht (
    .clk      (clk),
    .rd_idx   (fetch_idx),
    .rd_data  (pht_rd_data),
    .init_we  ((state_reg == STATE_INIT) && !rst),
    .init_idx (init_cnt_reg),
    .upd_we   (u_valid_reg && ready),
    .upd_idx  (upd_idx),
    .upd_taken(u_jump_reg)
  );

  // Fetch-side decode and prediction.
  assign fetch_opcode    = fetch_bp_instruction[6:0];
  assign fetch_is_branch = (fetch_opcode == OPCODE_BRANCH);
  assign fetch_is_jal    = (fetch_opcode == OPCODE_JAL);

  assign b_imm = {{(AW-13){fetch_bp_instruction[31]}}, fetch_bp_instruction[31],
                  fetch_bp_instruction[7], fetch_bp_instruction[30:25],
                  fetch_bp_instruction[11:8], 1'b0};
  assign j_imm = {{(AW-21){fetch_bp_instruction[31]}}, fetch_bp_instruction[31],
                  fetch_bp_instruction[19:12], fetch_bp_instruction[20],
                  fetch_bp_instruction[30:21], 1'b0};
  assign pc_plus4 = fetch_bp_pc + AW'(4);

  always_comb begin
    bp_fetch_predicted = 1'b0;
    bp_fetch_jump      = 1'b0;
    bp_fetch_next_pc   = pc_plus4;
    if (ready) begin
      if (fetch_is_branch) begin
        bp_fetch_predicted = 1'b1;
        bp_fetch_jump      = pht_rd_data[1];
        if (pht_rd_data[1]) bp_fetch_next_pc = fetch_bp_pc + b_imm;
      end else if (fetch_is_jal) begin
        bp_fetch_predicted = 1'b1;
        bp_fetch_jump      = 1'b1;
        bp_fetch_next_pc   = fetch_bp_pc + j_imm;
      end
    end
  end

  // Only resolved conditional branches train or repair; updates during init are dropped.
  assign exbru_is_branch = (exbru_bp_instruction[6:0] == OPCODE_BRANCH);
  assign upd_accept      = ready && exbru_bp_valid && exbru_is_branch;
  assign repair          = upd_accept && !exbru_bp_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= STATE_INIT;
      init_cnt_reg <= '0;
      ghr_reg      <= '0;
    end else begin
      if (state_reg == STATE_INIT) begin
        init_cnt_reg <= init_cnt_reg + 1'b1;
        if (init_cnt_reg == {PIW{1'b1}}) state_reg <= STATE_READY;
      end
      // Repair wins: the history that produced the mispredict is being discarded.
      if (repair) begin
        ghr_reg <= {exbru_bp_cp.global_history[GHR_WIDTH-2:0], exbru_bp_jump};
      end else if (ready && fetch_bp_valid && fetch_is_branch) begin
        ghr_reg <= {ghr_reg[GHR_WIDTH-2:0], bp_fetch_jump};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_valid_reg <= 1'b0;
    end else begin
      u_valid_reg <= upd_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_accept) begin
      u_pc_idx_reg <= exbru_bp_pc[PIW+1:2];
      u_jump_reg   <= exbru_bp_jump;
      u_ghr_reg    <= exbru_bp_cp.global_history[GHR_WIDTH-1:0];
    end
  end

`ifdef BP_STATISTICS_EN
  logic [31:0] stat_total_reg;
  logic [31:0] stat_miss_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_reg <= '0;
      stat_miss_reg  <= '0;
    end else if (upd_accept) begin
      if (stat_total_reg != 32'hFFFF_FFFF) stat_total_reg <= stat_total_reg + 32'd1;
      if (!exbru_bp_hit && (stat_miss_reg != 32'hFFFF_FFFF)) stat_miss_reg <= stat_miss_reg + 32'd1;
    end
  end

  assign bp_stat_total = stat_total_reg;
  assign bp_stat_miss  = stat_miss_reg;
`endif

  // Fields carried on the update bus that this predictor does not consume.
  logic unused_inputs;
  assign unused_inputs = ^{exbru_bp_instruction[`INSTRUCTION_WIDTH-1:7], exbru_bp_next_pc,
                           exbru_bp_pc[AW-1:PIW+2], exbru_bp_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare: init timing, prediction, training,
// saturation, GHR speculation/repair, reset restart and (with BP_STATISTICS_EN) counters.
module tb_branch_predictor_gshare;
  import branch_predictor_gshare_pkg::*;

  localparam logic [31:0] BEQ16  = 32'h0000_0863;  // beq x0,x0,+16
  localparam logic [31:0] JALM8  = 32'hFF9F_F06F;  // jal x0,-8
  localparam logic [31:0] JALR   = 32'h0000_8067;  // jalr x0,0(x1)
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_bp_valid = 1'b0;
  logic [31:0] fetch_bp_pc = 32'h100;
  logic [31:0] fetch_bp_instruction = BEQ16;
  logic        bp_fetch_predicted;
  logic        bp_fetch_jump;
  logic [31:0] bp_fetch_next_pc;
  logic [7:0]  bp_fetch_global_history;
  checkpoint_t exbru_bp_cp = '0;
  logic [31:0] exbru_bp_pc = '0;
  logic [31:0] exbru_bp_instruction = '0;
  logic        exbru_bp_jump = 1'b0;
  logic [31:0] exbru_bp_next_pc = '0;
  logic        exbru_bp_hit = 1'b1;
  logic        exbru_bp_valid = 1'b0;
  logic        bp_ready;
`ifdef BP_STATISTICS_EN
  logic [31:0] bp_stat_total;
  logic [31:0] bp_stat_miss;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare dut (
    .clk                    (clk),
    .rst                    (rst),
`ifdef BP_STATISTICS_EN
    .bp_stat_total          (bp_stat_total),
    .bp_stat_miss           (bp_stat_miss),
`endif
    .fetch_bp_valid         (fetch_bp_valid),
    .fetch_bp_pc            (fetch_bp_pc),
    .fetch_bp_instruction   (fetch_bp_instruction),
    .bp_fetch_predicted     (bp_fetch_predicted),
    .bp_fetch_jump          (bp_fetch_jump),
    .bp_fetch_next_pc       (bp_fetch_next_pc),
    .bp_fetch_global_history(bp_fetch_global_history),
    .exbru_bp_cp            (exbru_bp_cp),
    .exbru_bp_pc            (exbru_bp_pc),
    .exbru_bp_instruction   (exbru_bp_instruction),
    .exbru_bp_jump          (exbru_bp_jump),
    .exbru_bp_next_pc       (exbru_bp_next_pc),
    .exbru_bp_hit           (exbru_bp_hit),
    .exbru_bp_valid         (exbru_bp_valid),
    .bp_ready               (bp_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input logic [31:0] pc, input logic [31:0] inst);
    fetch_bp_valid       = 1'b0;
    fetch_bp_pc          = pc;
    fetch_bp_instruction = inst;
    #1;
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] inst, input logic jump,
                        input logic hit, input logic [7:0] hist);
    exbru_bp_valid              = 1'b1;
    exbru_bp_pc                 = pc;
    exbru_bp_instruction        = inst;
    exbru_bp_jump               = jump;
    exbru_bp_hit                = hit;
    exbru_bp_cp.global_history  = hist;
    exbru_bp_next_pc            = jump ? pc + 32'd16 : pc + 32'd4;
    tick();
    exbru_bp_valid = 1'b0;
  endtask

  // Counts edges after rst release until bp_ready rises; 0 means it never did.
  task automatic wait_ready(output int edges);
    edges = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (bp_ready) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int edges;
    rst = 1'b1;
    fetch_bp_valid = 1'b1;
    fetch_bp_pc = 32'h100;
    fetch_bp_instruction = BEQ16;
    repeat (3) tick();
    n_cmp++; if (bp_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %0b want 0", bp_ready); end
    n_cmp++; if (bp_fetch_predicted !== 1'b0) begin n_err++; $display("FAIL rst_predicted: got %0b want 0", bp_fetch_predicted); end
    n_cmp++; if (bp_fetch_jump !== 1'b0) begin n_err++; $display("FAIL rst_jump: got %0b want 0", bp_fetch_jump); end
    n_cmp++; if (bp_fetch_next_pc !== 32'h104) begin n_err++; $display("FAIL rst_next_pc: got %h want 00000104", bp_fetch_next_pc); end
    n_cmp++; if (bp_fetch_global_history !== 8'h00) begin n_err++; $display("FAIL rst_ghr: got %h want 00", bp_fetch_global_history); end
    rst = 1'b0;
    edges = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (i == 10) begin
        n_cmp++; if (bp_fetch_predicted !== 1'b0) begin n_err++; $display("FAIL init_predicted: got %0b want 0", bp_fetch_predicted); end
        n_cmp++; if (bp_fetch_jump !== 1'b0) begin n_err++; $display("FAIL init_jump: got %0b want 0", bp_fetch_jump); end
        n_cmp++; if (bp_fetch_next_pc !== 32'h104) begin n_err++; $display("FAIL init_next_pc: got %h want 00000104", bp_fetch_next_pc); end
        fetch_bp_valid = 1'b0;
      end
      if (bp_ready) begin
        edges = i;
        break;
      end
    end
    n_cmp++; if (edges != 256) begin n_err++; $display("FAIL init_cycles: got %0d want 256", edges); end
    n_cmp++; if (bp_fetch_global_history !== 8'h00) begin n_err++; $display("FAIL init_ghr: got %h want 00", bp_fetch_global_history); end
    $display("reset/init: ready after %0d edges", edges);
  endtask

  task automatic test_train();
    query(32'h100, BEQ16);
    n_cmp++; if (bp_fetch_predicted !== 1'b1) begin n_err++; $display("FAIL train_pred0: got %0b want 1", bp_fetch_predicted); end
    n_cmp++; if (bp_fetch_jump !== 1'b0) begin n_err++; $display("FAIL train_jump0: got %0b want 0", bp_fetch_jump); end
    n_cmp++; if (bp_fetch_next_pc !== 32'h104) begin n_err++; $display("FAIL train_next0: got %h want 00000104", bp_fetch_next_pc); end
    update(32'h100, BEQ16, 1'b1, 1'b0, 8'h00);
    update(32'h100, BEQ16, 1'b1, 1'b0, 8'h00);
    n_cmp++; if (bp_fetch_global_history !== 8'h01) begin n_err++; $display("FAIL train_repair_ghr: got %h want 01", bp_fetch_global_history); end
    update(32'h300, BEQ16, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++; if (bp_fetch_global_history !== 8'h00) begin n_err++; $display("FAIL train_ghr_zero: got %h want 00", bp_fetch_global_history); end
    query(32'h100, BEQ16);
    n_cmp++; if (bp_fetch_jump !== 1'b1) begin n_err++; $display("FAIL train_jump1: got %0b want 1", bp_fetch_jump); end
    n_cmp++; if (bp_fetch_next_pc !== 32'h110) begin n_err++; $display("FAIL train_next1: got %h want 00000110", bp_fetch_next_pc); end
    $display("train: pc 100 jump=%0b next=%h", bp_fetch_jump, bp_fetch_next_pc);
  endtask

  task automatic test_saturate();
    repeat (3) update(32'h100, BEQ16, 1'b1, 1'b1, 8'h00);
    update(32'h100, BEQ16, 1'b0, 1'b1, 8'h00);
    tick();
    query(32'h100, BEQ16);
    n_cmp++; if (bp_fetch_jump !== 1'b1) begin n_err++; $display("FAIL sat_hi_one_dec: got %0b want 1", bp_fetch_jump); end
    update(32'h100, BEQ16, 1'b0, 1'b1, 8'h00);
    tick();
    query(32'h100, BEQ16);
    n_cmp++; if (bp_fetch_jump !== 1'b0) begin n_err++; $display("FAIL sat_hi_two_dec: got %0b want 0", bp_fetch_jump); end
    update(32'h300, BEQ16, 1'b0, 1'b1, 8'h00);
    tick();
    query(32'h300, BEQ16);
    n_cmp++; if (bp_fetch_jump !== 1'b0) begin n_err++; $display("FAIL sat_lo: got %0b want 0", bp_fetch_jump); end
    n_cmp++; if (bp_fetch_next_pc !== 32'h304) begin n_err++; $display("FAIL sat_lo_next: got %h want 00000304", bp_fetch_next_pc); end
    n_cmp++; if (bp_fetch_global_history !== 8'h00) begin n_err++; $display("FAIL sat_ghr: got %h want 00", bp_fetch_global_history); end
    $display("saturate: pc 300 jump=%0b", bp_fetch_jump);
  endtask

  task automatic test_jal();
    query(32'h200, JALM8);
    n_cmp++; if (bp_fetch_predicted !== 1'b1) begin n_err++; $display("FAIL jal_pred: got %0b want 1", bp_fetch_predicted); end
    n_cmp++; if (bp_fetch_jump !== 1'b1) begin n_err++; $display("FAIL jal_jump: got %0b want 1", bp_fetch_jump); end
    n_cmp++; if (bp_fetch_next_pc !== 32'h1F8) begin n_err++; $display("FAIL jal_next: got %h want 000001f8", bp_fetch_next_pc); end
    fetch_bp_valid = 1'b1;
    tick();
    fetch_bp_valid = 1'b0;
    n_cmp++; if (bp_fetch_global_history !== 8'h00) begin n_err++; $display("FAIL jal_ghr: got %h want 00", bp_fetch_global_history); end
    query(32'h200, JALR);
    n_cmp++; if (bp_fetch_predicted !== 1'b0) begin n_err++; $display("FAIL jalr_pred: got %0b want 0", bp_fetch_predicted); end
    n_cmp++; if (bp_fetch_next_pc !== 32'h204) begin n_err++; $display("FAIL jalr_next: got %h want 00000204", bp_fetch_next_pc); end
    query(32'h204, MRET);
    n_cmp++; if (bp_fetch_jump !== 1'b0) begin n_err++; $display("FAIL mret_jump: got %0b want 0", bp_fetch_jump); end
    n_cmp++; if (bp_fetch_next_pc !== 32'h208) begin n_err++; $display("FAIL mret_next: got %h want 00000208", bp_fetch_next_pc); end
    update(32'h100, JALM8, 1'b1, 1'b0, 8'h55);
    tick();
    n_cmp++; if (bp_fetch_global_history !== 8'h00) begin n_err++; $display("FAIL jal_update_ghr: got %h want 00", bp_fetch_global_history); end
    $display("jal: next=%h ghr=%h", 32'h1F8, bp_fetch_global_history);
  endtask

  task automatic test_ghr_repair();
    logic [31:0] pcs [3];
    logic [7:0]  ghr_after [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h10C;
    ghr_after[0] = 8'h01; ghr_after[1] = 8'h03; ghr_after[2] = 8'h07;
    update(32'h100, BEQ16, 1'b1, 1'b1, 8'h00);
    update(32'h100, BEQ16, 1'b1, 1'b1, 8'h00);
    tick();
    for (int k = 0; k < 3; k++) begin
      query(pcs[k], BEQ16);
      n_cmp++; if (bp_fetch_jump !== 1'b1) begin n_err++; $display("FAIL spec_jump%0d: got %0b want 1", k, bp_fetch_jump); end
      fetch_bp_valid = 1'b1;
      tick();
      fetch_bp_valid = 1'b0;
      n_cmp++; if (bp_fetch_global_history !== ghr_after[k]) begin n_err++; $display("FAIL spec_ghr%0d: got %h want %h", k, bp_fetch_global_history, ghr_after[k]); end
    end
    // Mispredict repair arriving with a taken-predicted speculative query.
    query(32'h11C, BEQ16);
    fetch_bp_valid = 1'b1;
    update(32'h600, BEQ16, 1'b0, 1'b0, 8'h01);
    fetch_bp_valid = 1'b0;
    n_cmp++; if (bp_fetch_global_history !== 8'h02) begin n_err++; $display("FAIL repair_ghr: got %h want 02", bp_fetch_global_history); end
    $display("ghr repair: ghr=%h", bp_fetch_global_history);
  endtask

  task automatic test_restart();
    int edges;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (100) tick();
    n_cmp++; if (bp_ready !== 1'b0) begin n_err++; $display("FAIL midinit_ready: got %0b want 0", bp_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(edges);
    n_cmp++; if (edges != 256) begin n_err++; $display("FAIL restart_cycles: got %0d want 256", edges); end
    query(32'h100, BEQ16);
    n_cmp++; if (bp_fetch_jump !== 1'b0) begin n_err++; $display("FAIL restart_pht: got %0b want 0", bp_fetch_jump); end
    n_cmp++; if (bp_fetch_global_history !== 8'h00) begin n_err++; $display("FAIL restart_ghr: got %h want 00", bp_fetch_global_history); end
    $display("restart: ready after %0d edges", edges);
  endtask

`ifdef BP_STATISTICS_EN
  task automatic test_stats();
    n_cmp++; if (bp_stat_total !== 32'd0) begin n_err++; $display("FAIL stat_total_rst: got %0d want 0", bp_stat_total); end
    n_cmp++; if (bp_stat_miss !== 32'd0) begin n_err++; $display("FAIL stat_miss_rst: got %0d want 0", bp_stat_miss); end
    for (int k = 0; k < 10; k++) begin
      update(32'h400 + 32'(k * 4), BEQ16, 1'b1, (k >= 3), 8'h00);
    end
    update(32'h500, JALM8, 1'b1, 1'b0, 8'h00);
    tick();
    n_cmp++; if (bp_stat_total !== 32'd10) begin n_err++; $display("FAIL stat_total: got %0d want 10", bp_stat_total); end
    n_cmp++; if (bp_stat_miss !== 32'd3) begin n_err++; $display("FAIL stat_miss: got %0d want 3", bp_stat_miss); end
    $display("stats: total=%0d miss=%0d", bp_stat_total, bp_stat_miss);
  endtask
`endif

  initial begin
    test_reset();
    test_train();
    test_saturate();
    test_jal();
    test_ghr_repair();
    test_restart();
`ifdef BP_STATISTICS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
